// File: rtl/ram_march_ctrl.sv
// ram_march_ctrl: March C- BIST initiator for a single-port RAM with synchronous
// write and combinational read. Drives the RAM pins, checks every read against
// the expected background and reports pass/fail with the first fault location.
// Latency: first operation the cycle after an accepted start, 10*N operation
// cycles back to back, done on the following cycle (or the cycle after a failing read).
// Backpressure: none; start is ignored while busy, status holds until the next start.
//
// Ports:
//   clk, rst          rising-edge clock shared with the RAM, synchronous active-high reset
//   start             begin a test (sampled only when not busy)
//   ram_write_en      registered RAM write enable
//   ram_addr          registered RAM address
//   ram_data_in       registered RAM write data
//   ram_data_out      RAM combinational read data of ram_addr
//   busy, done, pass  test status; pass is meaningful while done=1
//   fail_elem/addr/data  march element, address and read word of the first mismatch
module ram_march_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        fail_elem,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [DATA_W-1:0] BG_Z     = '0;
  localparam logic [DATA_W-1:0] BG_O     = '1;
  localparam logic [2:0]        ELEM_LAST = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pass_q, pass_d;
  logic [2:0]        felem_q, felem_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;
  logic              wen_d;
  logic [DATA_W-1:0] wdata_d;
  logic              mismatch;
  logic              at_last;
  logic [2:0]        elem_inc;

  // Elements M3..M5 walk the address space downwards.
  function automatic logic is_down(input logic [2:0] e);
    return (e >= 3'd3);
  endfunction

  function automatic logic [ADDR_W-1:0] first_addr(input logic [2:0] e);
    return is_down(e) ? ADDR_MAX : '0;
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [2:0] e,
                                                   input logic [ADDR_W-1:0] a);
    return is_down(e) ? (a - 1'b1) : (a + 1'b1);
  endfunction

  // Background written by each element: M1 and M3 write ones, others zeros.
  function automatic logic [DATA_W-1:0] wr_bg(input logic [2:0] e);
    return (e == 3'd1 || e == 3'd3) ? BG_O : BG_Z;
  endfunction

  // Background expected by each element's read: M2 and M4 expect ones.
  function automatic logic [DATA_W-1:0] rd_bg(input logic [2:0] e);
    return (e == 3'd2 || e == 3'd4) ? BG_O : BG_Z;
  endfunction

  // Terminal address is detected inclusively so the counter never wraps
  // into the next element.
  assign at_last  = is_down(elem_q) ? (addr_q == '0) : (addr_q == ADDR_MAX);
  assign elem_inc = elem_q + 3'd1;
  assign mismatch = (state_q == RD) && (ram_data_out != rd_bg(elem_q));

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    felem_d = felem_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d = WR;
          elem_d  = '0;
          addr_d  = '0;
          pass_d  = 1'b0;
          felem_d = '0;
          faddr_d = '0;
          fdata_d = '0;
        end
      end

      WR: begin
        if (at_last) begin
          // Every element after M0 opens with a read at its own start address.
          state_d = RD;
          elem_d  = elem_inc;
          addr_d  = first_addr(elem_inc);
        end else begin
          // M0 is write-only; M1..M4 read the next address before writing it.
          state_d = (elem_q == 3'd0) ? WR : RD;
          addr_d  = next_addr(elem_q, addr_q);
        end
      end

      RD: begin
        if (mismatch) begin
          state_d = FIN;
          pass_d  = 1'b0;
          felem_d = elem_q;
          faddr_d = addr_q;
          fdata_d = ram_data_out;
          elem_d  = '0;
          addr_d  = '0;
        end else if (elem_q == ELEM_LAST) begin
          if (at_last) begin
            state_d = FIN;
            pass_d  = 1'b1;
            elem_d  = '0;
            addr_d  = '0;
          end else begin
            addr_d = next_addr(elem_q, addr_q);
          end
        end else begin
          // Read-then-write on the same address.
          state_d = WR;
        end
      end

      default: begin
        state_d = IDLE;
        elem_d  = '0;
        addr_d  = '0;
      end
    endcase

    wen_d   = (state_d == WR);
    wdata_d = (state_d == WR) ? wr_bg(elem_d) : BG_Z;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      elem_q       <= '0;
      addr_q       <= '0;
      pass_q       <= 1'b0;
      felem_q      <= '0;
      faddr_q      <= '0;
      fdata_q      <= '0;
      ram_write_en <= 1'b0;
      ram_data_in  <= '0;
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      addr_q       <= addr_d;
      pass_q       <= pass_d;
      felem_q      <= felem_d;
      faddr_q      <= faddr_d;
      fdata_q      <= fdata_d;
      ram_write_en <= wen_d;
      ram_data_in  <= wdata_d;
    end
  end

  // The address counter is cleared whenever the test is not running, so it
  // doubles as the registered RAM address.
  assign ram_addr  = addr_q;
  assign busy      = (state_q == WR) || (state_q == RD);
  assign done      = (state_q == FIN);
  assign pass      = pass_q;
  assign fail_elem = felem_q;
  assign fail_addr = faddr_q;
  assign fail_data = fdata_q;

endmodule

// File: tb/tb_ram_march_ctrl.sv
module tb_ram_march_ctrl;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int N      = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic              ram_write_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [2:0]        fail_elem;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;

  ram_march_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ram_write_en (ram_write_en),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_elem    (fail_elem),
    .fail_addr    (fail_addr),
    .fail_data    (fail_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model with selectable faults:
  // 0 good, 1 stuck-at-1 bit3 @5, 2 ignores addr bit2, 3 stuck-at-0 bit0 @0
  int                mode = 0;
  logic [DATA_W-1:0] mem [N];
  logic [ADDR_W-1:0] eff_addr;

  initial for (int i = 0; i < N; i++) mem[i] = '0;

  always_comb begin
    eff_addr = ram_addr;
    if (mode == 2) eff_addr[2] = 1'b0;
  end

  always @(posedge clk) if (ram_write_en) mem[eff_addr] <= ram_data_in;

  always_comb begin
    ram_data_out = mem[eff_addr];
    if (mode == 1 && eff_addr == 3'd5) ram_data_out[3] = 1'b1;
    if (mode == 3 && eff_addr == 3'd0) ram_data_out[0] = 1'b0;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic       pass;
    logic [2:0] elem;
    logic [2:0] addr;
    logic [7:0] data;
    int         busy_cyc;
    int         done_cyc;
    int         wr;
    int         rd;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input logic p, input int e, input int a, input int d,
                              input int bc, input int dc, input int w, input int r);
    exp_t x;
    x.pass = p; x.elem = 3'(e); x.addr = 3'(a); x.data = 8'(d);
    x.busy_cyc = bc; x.done_cyc = dc; x.wr = w; x.rd = r;
    return x;
  endfunction

  // Expected RAM operation for operation index i of a March C- run.
  task automatic exp_op(input int i, output logic we, output int a, output int d);
    int j, el, w, ai;
    d = 0;
    if (i < N) begin
      we = 1'b1; a = i;
    end else begin
      j = i - N;
      if (j < 8 * N) begin
        el = 1 + j / (2 * N);
        w  = j % (2 * N);
        ai = w / 2;
        we = (w % 2) == 1;
        a  = (el < 3) ? ai : (N - 1 - ai);
        if (we && (el == 1 || el == 3)) d = 8'hFF;
      end else begin
        we = 1'b0;
        a  = N - 1 - (j - 8 * N);
      end
    end
  endtask

  // Monitor: checks every operation cycle and pops the scoreboard on done.
  logic busy_prev = 1'b0;
  logic done_prev = 1'b0;
  int   bstart = 0, wr_cnt = 0, rd_cnt = 0;

  always @(negedge clk) begin
    logic e_we;
    int   e_a, e_d;
    exp_t x;
    chk("we_outside_busy", (ram_write_en && !busy) ? 1 : 0, 0);
    if (busy && !busy_prev) begin
      bstart = cyc; wr_cnt = 0; rd_cnt = 0;
    end
    if (busy) begin
      if (ram_write_en) wr_cnt++; else rd_cnt++;
      exp_op(cyc - bstart, e_we, e_a, e_d);
      if (e_we)
        chk("op_we_addr_data", {ram_write_en, 5'(ram_addr), ram_data_in},
            {1'b1, 5'(e_a), 8'(e_d)});
      else
        chk("op_we_addr", {ram_write_en, 5'(ram_addr)}, {1'b0, 5'(e_a)});
    end
    if (done && !done_prev) begin
      chk("sb_nonempty_at_done", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("pass", pass, x.pass);
        chk("fail_elem", fail_elem, x.elem);
        chk("fail_addr", fail_addr, x.addr);
        chk("fail_data", fail_data, x.data);
        chk("busy_start_cycle", bstart, x.busy_cyc);
        chk("done_cycle", cyc, x.done_cyc);
        chk("write_cycles", wr_cnt, x.wr);
        chk("read_cycles", rd_cnt, x.rd);
        chk("busy_at_done", busy, 0);
      end
    end
    busy_prev = busy;
    done_prev = done;
  end

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {ram_write_en, 5'(ram_addr), ram_data_in, busy, done, pass,
             fail_elem, 5'(fail_addr), fail_data}, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    at(3);
    rst = 1'b0;
    chk_all_zero("reset_values");

    // Good RAM: busy 11..90, done at 91.
    at(10); start = 1'b1; sb.push_back(mk(1, 0, 0, 0, 11, 91, 5 * N, 5 * N));
    at(11); start = 1'b0;

    // Stuck-at-1 bit3 at addr 5: fails at the M1 read of addr 5.
    at(95);  mode = 1;
    at(100); start = 1'b1; sb.push_back(mk(0, 1, 5, 8'h08, 101, 120, 13, 6));
    at(101); start = 1'b0;

    // Address alias: M1 read of addr 4 sees the ones just written to addr 0.
    at(125); mode = 2;
    at(130); start = 1'b1; sb.push_back(mk(0, 1, 4, 8'hFF, 131, 148, 12, 5));
    at(131); start = 1'b0;

    // Stuck-at-0 bit0 at addr 0: fails at the M2 read of addr 0.
    at(155); mode = 3;
    at(160); start = 1'b1; sb.push_back(mk(0, 2, 0, 8'hFE, 161, 186, 16, 9));
    at(161); start = 1'b0;

    // start held high for the whole test: exactly one run, status cleared on acceptance.
    at(190); mode = 0;
    at(200); start = 1'b1; sb.push_back(mk(1, 0, 0, 0, 201, 281, 5 * N, 5 * N));
    at(201);
    chk("clear_done", done, 0);
    chk("clear_fail_elem", fail_elem, 0);
    chk("clear_fail_data", fail_data, 0);
    chk("busy_after_start", busy, 1);
    at(281); start = 1'b0;

    // Restart from FIN, then abort it with a one-cycle reset.
    at(290);
    chk("done_held", done, 1);
    chk("pass_held", pass, 1);
    start = 1'b1;
    at(291); start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_clear_done", done, 0);
    chk("restart_clear_pass", pass, 0);
    at(310); rst = 1'b1;
    at(311); rst = 1'b0;
    chk_all_zero("midtest_reset_values");

    at(320); start = 1'b1; sb.push_back(mk(1, 0, 0, 0, 321, 401, 5 * N, 5 * N));
    at(321); start = 1'b0;

    while (sb.size() > 0 && cyc < 600) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
